fir_coeff_ctrl: RTL and testbench
=================================

Name: fir_coeff_ctrl

Overview:
- Controller that owns the 10x16 single-port coefficient SRAM (SpSram10x16) of the FIR filter and drives its chip-select, write-enable, address and write-data pins.
- Upstream side: accepts coefficient writes from the host/config path over a valid/ready handshake.
- Downstream side: on each new input sample, sweeps all taps out of the SRAM and presents them to the MAC stage as a tagged coefficient stream.

Parameters:
- NUM_TAPS, 10, number of coefficients/SRAM words used.
- ADDR_W, 4, SRAM address width.
- DATA_W, 16, coefficient width.
- RD_LAT, 1, SRAM read latency in cycles (address cycle to data cycle).

Ports:
- iClk12M  in  1  12 MHz system clock.
- iRst  in  1  synchronous reset, active-high.
- iCoeffWrEn  in  1  host write request (valid).
- iCoeffAddr  in  ADDR_W  host write tap index.
- iCoeffData  in  DATA_W  host write coefficient.
- oCoeffWrRdy  out  1  write accepted when iCoeffWrEn & oCoeffWrRdy.
- oAddrErr  out  1  1-cycle pulse: accepted write had iCoeffAddr >= NUM_TAPS.
- iSampleVld  in  1  1-cycle pulse: new sample, start coefficient sweep.
- oOverrun  out  1  1-cycle pulse: iSampleVld arrived while busy.
- oBusy  out  1  sweep or write in progress.
- oCoeffVld  out  1  coefficient stream valid.
- oCoeffTap  out  ADDR_W  tap index of oCoeffDt.
- oCoeffDt  out  DATA_W  coefficient value.
- oSweepDone  out  1  asserted together with the last tap (NUM_TAPS-1).
- oCsnRam  out  1  SRAM chip select, active-low.
- oWrnRam  out  1  SRAM write enable, active-low.
- oAddrRam  out  ADDR_W  SRAM address.
- oWtDtRam  out  DATA_W  SRAM write data.
- iRdDtRam  in  DATA_W  SRAM read data.

Behaviour:
- Reset values (iRst high at an edge; applies even mid-operation):
  - oCsnRam=1, oWrnRam=1, oAddrRam=0, oWtDtRam=0.
  - oCoeffVld=0, oCoeffTap=0, oCoeffDt=0, oSweepDone=0, oAddrErr=0, oOverrun=0.
  - State=IDLE; in-flight read pipeline flushed.
- All SRAM-side outputs and stream outputs are registered.
- oCoeffWrRdy = (state==IDLE) & ~iSampleVld & ~iRst (combinational).
- oBusy = (state!=IDLE).
- FSM states: IDLE, WR, RD, DRAIN.
- IDLE:
  - iSampleVld=1 -> RD with tap counter=0. A sweep has priority over a simultaneous write; the write is not accepted and the host holds it.
  - Else, accepted write with addr < NUM_TAPS -> WR; addr/data captured.
  - Accepted write with addr >= NUM_TAPS -> write dropped, oAddrErr pulses next cycle, stay IDLE, SRAM pins untouched.
- WR: exactly one cycle with oCsnRam=0, oWrnRam=0, oAddrRam/oWtDtRam = captured values; SRAM writes at the following edge; then IDLE. Max write throughput is one per 2 cycles.
- RD:
  - For NUM_TAPS consecutive cycles: oCsnRam=0, oWrnRam=1, oAddrRam = 0,1,...,NUM_TAPS-1.
  - After the last address -> DRAIN.
- DRAIN:
  - oCsnRam=1, oWrnRam=1, oAddrRam=0.
  - Wait RD_LAT+1 cycles for the pipeline to empty, then IDLE.
- Read timing:
  - Address n on oAddrRam in cycle c -> iRdDtRam valid in cycle c+RD_LAT.
  - Registered into oCoeffDt with oCoeffVld=1 and oCoeffTap=n in cycle c+RD_LAT+1.
  - End to end: iSampleVld high in cycle s -> tap0 on the stream in cycle s+2+RD_LAT (s+3 default); tap NUM_TAPS-1 in cycle s+NUM_TAPS+1+RD_LAT, with oSweepDone=1 in that cycle.
  - oCoeffVld is contiguous for exactly NUM_TAPS cycles per sweep; tap index wraps to 0 only by starting a new sweep.
- iSampleVld while oBusy: ignored, no state change, oOverrun pulses next cycle.
- Earliest next sweep: iSampleVld in the first IDLE cycle after DRAIN.
- oWtDtRam holds its last written value outside WR.

Decomposition:
- Package fir_pkg: NUM_TAPS, ADDR_W, DATA_W, RD_LAT defaults, and the FSM state enum (IDLE/WR/RD/DRAIN).
- One sub-module, fir_rd_lat_pipe: a RD_LAT+1-deep shift register carrying {valid, tap, last} alongside the SRAM access and sampling iRdDtRam at its final stage.

Test Plan:
- Write 16'hA000+n to taps 0..9 (back-to-back requests held until ready), then pulse iSampleVld -> each write shows exactly one Csn=0/Wrn=0 cycle; stream shows taps 0..9 = A000..A009 on consecutive cycles starting 3 cycles after the pulse; oSweepDone with tap 9 only.
- Write addr 4'hA, data 16'h1234 -> oAddrErr one pulse, oCsnRam stays 1; following sweep still returns A000..A009.
- iCoeffWrEn (addr 3, 16'hBEEF) and iSampleVld in the same cycle -> sweep runs with tap3=A003, oCoeffWrRdy low until IDLE, then write lands; next sweep gives tap3=BEEF.
- iSampleVld pulsed again at tap 5 of a sweep -> oOverrun pulses once, stream still completes 10 taps, no second sweep.
- iRst asserted for one cycle during RD at address 6 -> next cycle all outputs at reset values, no further oCoeffVld; a fresh sweep afterwards returns all 10 taps correctly.
- Two sweeps with iSampleVld at the earliest legal cycle -> two contiguous 10-tap bursts, no overrun, identical data.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared constants and types for the FIR coefficient SRAM controller.
package fir_pkg;

  localparam int NUM_TAPS = 10;
  localparam int ADDR_W   = 4;
  localparam int DATA_W   = 16;
  localparam int RD_LAT   = 1;
  localparam int DRAIN_W  = $clog2(RD_LAT + 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR    = 2'd1,
    RD    = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Tag that travels alongside each SRAM read until its data comes back.
  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] tap;
    logic              last;
  } tap_tag_t;

endpackage

// File: rtl/fir_coeff_ctrl_if.sv
// Host write port, sample trigger, coefficient stream and SRAM pins of fir_coeff_ctrl.
interface fir_coeff_ctrl_if;
  import fir_pkg::*;

  // Host write handshake: a write transfers in any cycle where iCoeffWrEn and
  // oCoeffWrRdy are both high; the host holds iCoeffAddr/iCoeffData stable
  // and keeps iCoeffWrEn high until that cycle.
  logic              iCoeffWrEn;
  logic [ADDR_W-1:0] iCoeffAddr;
  logic [DATA_W-1:0] iCoeffData;
  logic              oCoeffWrRdy;
  logic              oAddrErr;

  logic              iSampleVld;
  logic              oOverrun;
  logic              oBusy;
  logic              oCoeffVld;
  logic [ADDR_W-1:0] oCoeffTap;
  logic [DATA_W-1:0] oCoeffDt;
  logic              oSweepDone;

  logic              oCsnRam;
  logic              oWrnRam;
  logic [ADDR_W-1:0] oAddrRam;
  logic [DATA_W-1:0] oWtDtRam;
  logic [DATA_W-1:0] iRdDtRam;

  state_t            dbg_state;

  modport master (
    output iCoeffWrEn, iCoeffAddr, iCoeffData, iSampleVld, iRdDtRam,
    input  oCoeffWrRdy, oAddrErr, oOverrun, oBusy, oCoeffVld, oCoeffTap,
    input  oCoeffDt, oSweepDone, oCsnRam, oWrnRam, oAddrRam, oWtDtRam,
    input  dbg_state
  );

  modport slave (
    input  iCoeffWrEn, iCoeffAddr, iCoeffData, iSampleVld, iRdDtRam,
    output oCoeffWrRdy, oAddrErr, oOverrun, oBusy, oCoeffVld, oCoeffTap,
    output oCoeffDt, oSweepDone, oCsnRam, oWrnRam, oAddrRam, oWtDtRam,
    output dbg_state
  );

endinterface

// File: rtl/fir_rd_lat_pipe.sv
// Carries the {valid, tap, last} tag of each SRAM read for RD_LAT+1 cycles and
// captures the returned SRAM word in the final stage.
module fir_rd_lat_pipe
  import fir_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  tap_tag_t          tag_i,
  input  logic [DATA_W-1:0] rd_data_i,
  output tap_tag_t          tag_o,
  output logic [DATA_W-1:0] data_o
);

  tap_tag_t          stage_q [RD_LAT+1];
  tap_tag_t          stage_d [RD_LAT+1];
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_d;

  // The tag entering the last stage belongs to the word on rd_data_i this cycle.
  always_comb begin
    stage_d[0] = tag_i;
    for (int i = 1; i <= RD_LAT; i++) begin
      stage_d[i] = stage_q[i-1];
    end
    data_d = data_q;
    if (stage_d[RD_LAT].valid) begin
      data_d = rd_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= RD_LAT; i++) begin
        stage_q[i] <= '0;
      end
      data_q <= '0;
    end else begin
      for (int i = 0; i <= RD_LAT; i++) begin
        stage_q[i] <= stage_d[i];
      end
      data_q <= data_d;
    end
  end

  assign tag_o  = stage_q[RD_LAT];
  assign data_o = data_q;

endmodule

// File: rtl/fir_coeff_ctrl.sv
// Owns the coefficient SRAM: single-cycle host writes, and a full-tap read sweep
// per input sample delivered to the MAC as a tagged coefficient stream.
module fir_coeff_ctrl
  import fir_pkg::*;
(
  input logic            iClk12M,
  input logic            iRst,
  fir_coeff_ctrl_if.slave bus
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] tap_q, tap_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic              csn_q, csn_d;
  logic              wrn_q, wrn_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              addr_err_q, addr_err_d;
  logic              overrun_q, overrun_d;
  logic              wr_rdy;
  logic              wr_fire;
  tap_tag_t          rd_tag;
  tap_tag_t          out_tag;
  logic [DATA_W-1:0] out_data;

  assign wr_rdy  = (state_q == IDLE) & ~bus.iSampleVld & ~iRst;
  assign wr_fire = bus.iCoeffWrEn & wr_rdy;

  // SRAM pins are registered, so they are derived from the state being entered.
  always_comb begin
    state_d    = state_q;
    tap_d      = tap_q;
    drain_d    = drain_q;
    csn_d      = 1'b1;
    wrn_d      = 1'b1;
    addr_d     = '0;
    wdata_d    = wdata_q;
    addr_err_d = 1'b0;
    overrun_d  = bus.iSampleVld & (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        if (bus.iSampleVld) begin
          state_d = RD;
          tap_d   = '0;
        end else if (wr_fire) begin
          if (bus.iCoeffAddr < ADDR_W'(NUM_TAPS)) begin
            state_d = WR;
            csn_d   = 1'b0;
            wrn_d   = 1'b0;
            addr_d  = bus.iCoeffAddr;
            wdata_d = bus.iCoeffData;
          end else begin
            addr_err_d = 1'b1;
          end
        end
      end
      WR: begin
        state_d = IDLE;
      end
      RD: begin
        if (tap_q == ADDR_W'(NUM_TAPS - 1)) begin
          state_d = DRAIN;
          drain_d = '0;
        end else begin
          tap_d = tap_q + ADDR_W'(1);
        end
      end
      DRAIN: begin
        if (drain_q == DRAIN_W'(RD_LAT)) begin
          state_d = IDLE;
        end else begin
          drain_d = drain_q + DRAIN_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (state_d == RD) begin
      csn_d  = 1'b0;
      addr_d = tap_d;
    end
  end

  always_ff @(posedge iClk12M) begin
    if (iRst) begin
      state_q    <= IDLE;
      tap_q      <= '0;
      drain_q    <= '0;
      csn_q      <= 1'b1;
      wrn_q      <= 1'b1;
      addr_q     <= '0;
      wdata_q    <= '0;
      addr_err_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tap_q      <= tap_d;
      drain_q    <= drain_d;
      csn_q      <= csn_d;
      wrn_q      <= wrn_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      addr_err_q <= addr_err_d;
      overrun_q  <= overrun_d;
    end
  end

  // Tag the read whose address is on the SRAM pins this cycle.
  always_comb begin
    rd_tag = '0;
    if (state_q == RD) begin
      rd_tag.valid = 1'b1;
      rd_tag.tap   = addr_q;
      rd_tag.last  = (addr_q == ADDR_W'(NUM_TAPS - 1));
    end
  end

  fir_rd_lat_pipe u_rd_pipe (
    .clk       (iClk12M),
    .rst       (iRst),
    .tag_i     (rd_tag),
    .rd_data_i (bus.iRdDtRam),
    .tag_o     (out_tag),
    .data_o    (out_data)
  );

  assign bus.oCoeffWrRdy = wr_rdy;
  assign bus.oAddrErr    = addr_err_q;
  assign bus.oOverrun    = overrun_q;
  assign bus.oBusy       = (state_q != IDLE);
  assign bus.oCoeffVld   = out_tag.valid;
  assign bus.oCoeffTap   = out_tag.tap;
  assign bus.oSweepDone  = out_tag.last;
  assign bus.oCoeffDt    = out_data;
  assign bus.oCsnRam     = csn_q;
  assign bus.oWrnRam     = wrn_q;
  assign bus.oAddrRam    = addr_q;
  assign bus.oWtDtRam    = wdata_q;
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_fir_coeff_ctrl.sv
// Bench for fir_coeff_ctrl: acts as host and SRAM, predicts pin activity and the
// coefficient stream from a transaction-level model of writes and sweeps.
module tb_fir_coeff_ctrl;
  import fir_pkg::*;

  localparam int FIRST_LAT  = 2 + RD_LAT;           // pulse cycle -> tap 0 on stream
  localparam int SWEEP_BUSY = NUM_TAPS + 1 + RD_LAT; // last non-idle cycle after pulse

  logic clk = 1'b0;
  logic rst = 1'b1;

  fir_coeff_ctrl_if bus();

  fir_coeff_ctrl dut (
    .iClk12M (clk),
    .iRst    (rst),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  // SRAM model with one cycle read latency; contents survive controller reset.
  logic [DATA_W-1:0] sram [16];
  always @(posedge clk) begin
    if (!bus.oCsnRam) begin
      if (!bus.oWrnRam) sram[bus.oAddrRam] <= bus.oWtDtRam;
      else              bus.iRdDtRam <= sram[bus.oAddrRam];
    end
  end

  // Reference model state.
  logic [DATA_W-1:0] mdl_mem [NUM_TAPS];
  logic [52:0]       exp_q[$];   // {cycle[31:0], tap[3:0], data[15:0], last}
  int                pin_kind[int]; // 1 = read, 2 = write
  int                pin_addr[int];
  int                pin_data[int];
  int                cyc;
  int                busy_until;
  bit                exp_err, exp_ovr, chk_rst_now, wr_acc;
  int                n_cmp, n_bad;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %0h want %0h", tag, cyc, act, exp);
    end
  endtask

  task automatic tick();
    logic [52:0] e;
    @(negedge clk);
    if (chk_rst_now) begin
      chk("rst_csn", bus.oCsnRam, 1);
      chk("rst_wrn", bus.oWrnRam, 1);
      chk("rst_addr", bus.oAddrRam, 0);
      chk("rst_wdata", bus.oWtDtRam, 0);
      chk("rst_vld", bus.oCoeffVld, 0);
      chk("rst_tap", bus.oCoeffTap, 0);
      chk("rst_dt", bus.oCoeffDt, 0);
      chk("rst_done", bus.oSweepDone, 0);
      chk("rst_state", bus.dbg_state, IDLE);
      chk_rst_now = 1'b0;
    end
    chk("wr_rdy", bus.oCoeffWrRdy, !rst && !bus.iSampleVld && (cyc > busy_until));
    chk("busy", bus.oBusy, cyc <= busy_until);
    chk("addr_err", bus.oAddrErr, exp_err);
    chk("overrun", bus.oOverrun, exp_ovr);
    if (pin_kind.exists(cyc)) begin
      chk("ram_csn", bus.oCsnRam, 0);
      chk("ram_wrn", bus.oWrnRam, (pin_kind[cyc] == 1) ? 1 : 0);
      chk("ram_addr", bus.oAddrRam, pin_addr[cyc]);
      if (pin_kind[cyc] == 2) chk("ram_wdata", bus.oWtDtRam, pin_data[cyc]);
      pin_kind.delete(cyc);
    end else begin
      chk("ram_idle", {bus.oCsnRam, bus.oWrnRam}, 2'b11);
    end
    if (exp_q.size() > 0 && int'(exp_q[0][52:21]) == cyc) begin
      e = exp_q.pop_front();
      chk("vld", bus.oCoeffVld, 1);
      chk("tap", bus.oCoeffTap, e[20:17]);
      chk("coeff", bus.oCoeffDt, e[16:1]);
      chk("done", bus.oSweepDone, e[0]);
    end else begin
      chk("vld_idle", bus.oCoeffVld, 0);
      chk("done_idle", bus.oSweepDone, 0);
    end

    // Predict the effect of this cycle's inputs.
    wr_acc  = 1'b0;
    exp_err = 1'b0;
    exp_ovr = 1'b0;
    if (rst) begin
      exp_q.delete();
      pin_kind.delete();
      busy_until = cyc;
    end else if (bus.iSampleVld) begin
      if (cyc <= busy_until) begin
        exp_ovr = 1'b1;
      end else begin
        for (int k = 0; k < NUM_TAPS; k++) begin
          pin_kind[cyc + 1 + k] = 1;
          pin_addr[cyc + 1 + k] = k;
          exp_q.push_back({32'(cyc + FIRST_LAT + k), 4'(k), mdl_mem[k], k == NUM_TAPS - 1});
        end
        busy_until = cyc + SWEEP_BUSY;
      end
    end else if (bus.iCoeffWrEn && cyc > busy_until) begin
      wr_acc = 1'b1;
      if (int'(bus.iCoeffAddr) < NUM_TAPS) begin
        mdl_mem[bus.iCoeffAddr] = bus.iCoeffData;
        pin_kind[cyc + 1] = 2;
        pin_addr[cyc + 1] = int'(bus.iCoeffAddr);
        pin_data[cyc + 1] = int'(bus.iCoeffData);
        busy_until = cyc + 1;
      end else begin
        exp_err = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse_sample();
    bus.iSampleVld = 1'b1;
    tick();
    bus.iSampleVld = 1'b0;
  endtask

  // Host write held until accepted; optionally collides with a sample pulse.
  task automatic write_coeff(input int a, input int d, input bit with_sv);
    int n = 0;
    bus.iCoeffWrEn = 1'b1;
    bus.iCoeffAddr = ADDR_W'(a);
    bus.iCoeffData = DATA_W'(d);
    bus.iSampleVld = with_sv;
    do begin
      tick();
      bus.iSampleVld = 1'b0;
      n++;
    end while (!wr_acc && n < 40);
    bus.iCoeffWrEn = 1'b0;
    if (!wr_acc) chk("wr_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.iCoeffWrEn = 1'b0;
    bus.iCoeffAddr = '0;
    bus.iCoeffData = '0;
    bus.iSampleVld = 1'b0;
    n_cmp = 0; n_bad = 0; cyc = 0;
    exp_err = 1'b0; exp_ovr = 1'b0; wr_acc = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    busy_until  = cyc - 1;
    chk_rst_now = 1'b1;

    // Fill all taps back to back, then sweep.
    for (int n = 0; n < NUM_TAPS; n++) write_coeff(n, 16'hA000 + n, 1'b0);
    pulse_sample();
    idle(15);

    // Out-of-range write is dropped with an error pulse.
    write_coeff(4'hA, 16'h1234, 1'b0);
    idle(2);
    pulse_sample();
    idle(15);

    // Sweep wins over a simultaneous write; the write lands afterwards.
    write_coeff(3, 16'hBEEF, 1'b1);
    idle(2);
    pulse_sample();
    idle(15);

    // Second pulse during tap 5 of a sweep.
    pulse_sample();
    idle(FIRST_LAT + 5 - 1);
    pulse_sample();
    idle(15);

    // Reset while address 6 is on the SRAM pins.
    pulse_sample();
    idle(6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_rst_now = 1'b1;
    idle(5);
    pulse_sample();
    idle(15);

    // Back-to-back sweeps at the earliest legal cycle.
    pulse_sample();
    idle(SWEEP_BUSY);
    pulse_sample();
    idle(15);

    // Randomized mix of writes, sweeps, collisions and overruns.
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 3))
        0: write_coeff($urandom_range(0, 15), $urandom_range(0, 16'hFFFF), 1'b0);
        1: begin
          pulse_sample();
          idle($urandom_range(0, 16));
        end
        2: begin
          pulse_sample();
          idle($urandom_range(1, 14));
          pulse_sample();
        end
        default: write_coeff($urandom_range(0, 15), $urandom_range(0, 16'hFFFF), 1'b1);
      endcase
    end
    idle(20);
    chk("stream_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
